stream_syn_fifo_controller: RTL and testbench
=============================================

# stream_syn_fifo_controller

Single-clock stream (frame) FIFO controller: the next generation of the team's stream FIFO controllers for designs where producer and consumer share one clock. It manages write/read addressing of an external 1-cycle-latency synchronous RAM of arbitrary (even) depth. Only committed frames are exposed to the read side; uncommitted frames can be aborted. New capabilities are per-frame head reservation with random-access head writes, an almost-full threshold, and an optional drop-on-overflow mode.

## Interface
- FWFTEN, 1: 1 = first-word-fall-through read; 0 = standard read.
- ADDRWIDTH, 6: RAM address width.
- FIFODEPTH, 44: RAM words; even; 2 ≤ FIFODEPTH ≤ 2^ADDRWIDTH.
- HEADSIZE, 0: words reserved at the start of each frame; HEADSIZE < FIFODEPTH.
- AFULLTH, 40: w_afull asserts when w_counter ≥ AFULLTH.
- DROPEN, 0: 1 = an overflowing frame is dropped whole.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- w_ctrl  in  3  0 NOP, 1 WRITE, 2 COMMIT, 3 ABORT, 4 HEADWR, 5-7 illegal.
- w_head_idx  in  ADDRWIDTH  head word index for HEADWR.
- w_full  out  1  next WRITE cannot be accepted.
- w_afull  out  1  almost full.
- w_error  out  1  one-cycle error pulse.
- w_counter  out  ADDRWIDTH+1  words in use, including uncommitted words and reserved head words.
- r_en  in  1  read request (FWFTEN=0) or acknowledge (FWFTEN=1).
- r_valid  out  1  RAM read data valid this cycle.
- r_error  out  1  one-cycle read-underflow pulse.
- r_counter  out  ADDRWIDTH+1  committed words not yet fetched from RAM.
- w_ram_addr  out  ADDRWIDTH  RAM write address.
- w_ram_en  out  1  RAM write enable.
- r_ram_addr  out  ADDRWIDTH  RAM read address.
- r_ram_en  out  1  RAM read enable.

## Operation
- Internal registers:
  - rptr: next read address.
  - cptr: commit pointer, i.e. start of the current frame.
  - wptr: working write pointer.
  - All three are binary, in range 0..FIFODEPTH-1, and wrap from FIFODEPTH-1 to 0.
- Write FSM states:
  - IDLE: no frame is open.
  - FRAME: a frame is open.
  - DROP: only when DROPEN=1; the open frame is being discarded.
- IDLE + WRITE:
  - Requires at least HEADSIZE+1 free words.
  - Data word goes to address cptr+HEADSIZE (mod depth); wptr = cptr+HEADSIZE+1; go to FRAME.
  - If insufficient space: no write, w_error pulse, stay in IDLE.
- FRAME + WRITE:
  - If w_counter < FIFODEPTH: write at wptr, wptr+1.
  - Else, DROPEN=0: no write, w_error pulse, stay in FRAME.
  - Else, DROPEN=1: no write, w_error pulse, go to DROP.
- FRAME + HEADWR: if w_head_idx < HEADSIZE, write at cptr+w_head_idx (mod depth) with no pointer change. Otherwise w_error pulse and no write.
- FRAME + COMMIT: cptr ← wptr; r_counter += frame length (HEADSIZE + data words); go to IDLE.
- FRAME + ABORT: wptr ← cptr; go to IDLE.
- DROP:
  - WRITE and HEADWR are ignored silently.
  - COMMIT or ABORT: wptr ← cptr, go to IDLE.
- In IDLE: COMMIT and ABORT are no-ops; HEADWR gives a w_error pulse. Illegal codes give a w_error pulse in any state.
- w_ram_en and w_ram_addr are combinational from w_ctrl and state. Write data is therefore aligned with the w_ctrl cycle.
- Read, FWFTEN=0:
  - r_ram_en = r_en & (r_counter≠0).
  - r_en while r_counter=0 gives an r_error pulse.
- Read, FWFTEN=1:
  - r_ram_en = (r_counter≠0) & (~r_valid | r_en).
  - r_en while ~r_valid gives an r_error pulse.
- In both modes, r_ram_en advances rptr by 1 and decrements r_counter.
- Counters:
  - w_counter = words from rptr to wptr.
  - w_full = (state==IDLE) ? (FIFODEPTH−w_counter < HEADSIZE+1) : (w_counter==FIFODEPTH).
  - Simultaneous read and write/commit in one cycle: apply both deltas in that cycle, with no loss.
- Pointer arithmetic uses ADDRWIDTH+1 bits. Subtract FIFODEPTH when the sum is ≥ FIFODEPTH.

## Timing
- Reset (asynchronous) values:
  - All pointers and counters = 0; state = IDLE.
  - w_error, r_error, r_valid, w_afull = 0; w_full = 0; r_ram_en = 0; w_ram_en = 0.
- A reset mid-frame discards all data.
- w_counter, r_counter, w_full and w_afull are registered and update the cycle after the causing event.
- A COMMIT in cycle N: r_counter is nonzero from N+1. With FWFTEN=1, r_ram_en is high in N+1 and r_valid is high in N+2.
- r_valid = r_ram_en delayed by one cycle, held while ~r_en (FWFTEN=1). With FWFTEN=0, r_valid is a one-cycle pulse per read.
- w_error and r_error are registered pulses, asserted in the cycle after the offending command.

## Test plan
- Defaults, FWFTEN=1. Write 5 words, then COMMIT: r_counter 0→5 the cycle after COMMIT; r_valid rises two cycles after COMMIT; reads return addresses 0..4; r_counter ends at 0.
- HEADSIZE=2. WRITE×3, HEADWR idx 0 and 1, COMMIT: data at addresses 2,3,4; head at 0,1; r_counter=5; HEADWR idx 2 gives a w_error pulse.
- Write 10 words and ABORT; then write 3 words and COMMIT: the second frame starts at address 0; r_counter=3; w_counter=3.
- DROPEN=0: 45 WRITEs into an empty FIFO: w_full after the 44th; the 45th gives a w_error pulse and no w_ram_en. DROPEN=1: same stimulus then COMMIT: w_counter=0, r_counter=0.
- Wrap-around: cptr=40; write and commit 8 words: addresses 40..43 then 0..3; interleaved reads and writes keep w_counter exact.
- FWFTEN=0: r_en on empty gives r_error; reset asserted mid-frame gives all outputs 0 immediately.

Source files
------------

// File: rtl/stream_syn_fifo_controller.sv
// ============================================================================
// Module   : stream_syn_fifo_controller
// Brief    : Single-clock frame FIFO controller for an external 1-cycle RAM,
//            with head reservation, almost-full flag and drop-on-overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_syn_fifo_controller #(
    parameter int FWFTEN    = 1,
    parameter int ADDRWIDTH = 6,
    parameter int FIFODEPTH = 44,
    parameter int HEADSIZE  = 0,
    parameter int AFULLTH   = 40,
    parameter int DROPEN    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           w_ctrl,
    input  logic [ADDRWIDTH-1:0] w_head_idx,
    output logic                 w_full,
    output logic                 w_afull,
    output logic                 w_error,
    output logic [ADDRWIDTH:0]   w_counter,
    input  logic                 r_en,
    output logic                 r_valid,
    output logic                 r_error,
    output logic [ADDRWIDTH:0]   r_counter,
    output logic [ADDRWIDTH-1:0] w_ram_addr,
    output logic                 w_ram_en,
    output logic [ADDRWIDTH-1:0] r_ram_addr,
    output logic                 r_ram_en
);

    typedef logic [ADDRWIDTH:0]   cnt_t;
    typedef logic [ADDRWIDTH-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(FIFODEPTH);
    localparam cnt_t HEAD_C  = cnt_t'(HEADSIZE);
    localparam cnt_t HEAD1_C = cnt_t'(HEADSIZE + 1);
    localparam cnt_t AFULL_C = cnt_t'(AFULLTH);

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_WRITE  = 3'd1;
    localparam logic [2:0] CMD_COMMIT = 3'd2;
    localparam logic [2:0] CMD_ABORT  = 3'd3;
    localparam logic [2:0] CMD_HEADWR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t state_q, state_d;
    ptr_t   rptr_q, rptr_d;
    ptr_t   cptr_q, cptr_d;
    ptr_t   wptr_q, wptr_d;
    cnt_t   flen_q, flen_d;
    cnt_t   rcnt_q, rcnt_d;
    cnt_t   wcnt_q, wcnt_d;
    logic   wfull_q, wfull_d;
    logic   wafull_q, wafull_d;
    logic   werr_q, werr_d;
    logic   rerr_q, rerr_d;
    logic   rvalid_q, rvalid_d;

    logic   wr_en;
    ptr_t   wr_addr;
    logic   rd_en;
    cnt_t   commit_len;
    logic   head_ok;

    // Modular add: inc never exceeds the depth, so one correction is enough.
    function automatic ptr_t ptr_add(input ptr_t p, input cnt_t inc);
        cnt_t s;
        s = {1'b0, p} + inc;
        if (s >= DEPTH_C) begin
            s = s - DEPTH_C;
        end
        return s[ADDRWIDTH-1:0];
    endfunction

    assign head_ok = ((cnt_t'(w_head_idx) + cnt_t'(1)) <= HEAD_C);

    always_comb begin
        state_d    = state_q;
        cptr_d     = cptr_q;
        wptr_d     = wptr_q;
        flen_d     = flen_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        werr_d     = 1'b0;
        commit_len = '0;
        case (state_q)
            ST_IDLE: begin
                case (w_ctrl)
                    CMD_NOP, CMD_COMMIT, CMD_ABORT: ;
                    CMD_WRITE: begin
                        if ((DEPTH_C - wcnt_q) >= HEAD1_C) begin
                            wr_en   = 1'b1;
                            wr_addr = ptr_add(cptr_q, HEAD_C);
                            wptr_d  = ptr_add(cptr_q, HEAD1_C);
                            flen_d  = HEAD1_C;
                            state_d = ST_FRAME;
                        end else begin
                            werr_d = 1'b1;
                        end
                    end
                    default: werr_d = 1'b1;
                endcase
            end
            ST_FRAME: begin
                case (w_ctrl)
                    CMD_NOP: ;
                    CMD_WRITE: begin
                        if (wcnt_q < DEPTH_C) begin
                            wr_en   = 1'b1;
                            wr_addr = wptr_q;
                            wptr_d  = ptr_add(wptr_q, cnt_t'(1));
                            flen_d  = flen_q + cnt_t'(1);
                        end else begin
                            werr_d = 1'b1;
                            if (DROPEN != 0) begin
                                state_d = ST_DROP;
                            end
                        end
                    end
                    CMD_HEADWR: begin
                        if (head_ok) begin
                            wr_en   = 1'b1;
                            wr_addr = ptr_add(cptr_q, cnt_t'(w_head_idx));
                        end else begin
                            werr_d = 1'b1;
                        end
                    end
                    CMD_COMMIT: begin
                        cptr_d     = wptr_q;
                        commit_len = flen_q;
                        flen_d     = '0;
                        state_d    = ST_IDLE;
                    end
                    CMD_ABORT: begin
                        wptr_d  = cptr_q;
                        flen_d  = '0;
                        state_d = ST_IDLE;
                    end
                    default: werr_d = 1'b1;
                endcase
            end
            ST_DROP: begin
                case (w_ctrl)
                    CMD_NOP, CMD_WRITE, CMD_HEADWR: ;
                    CMD_COMMIT, CMD_ABORT: begin
                        wptr_d  = cptr_q;
                        flen_d  = '0;
                        state_d = ST_IDLE;
                    end
                    default: werr_d = 1'b1;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (FWFTEN != 0) begin
            rd_en    = (rcnt_q != '0) && (!rvalid_q || r_en);
            rerr_d   = r_en && !rvalid_q;
            rvalid_d = rd_en ? 1'b1 : (r_en ? 1'b0 : rvalid_q);
        end else begin
            rd_en    = r_en && (rcnt_q != '0);
            rerr_d   = r_en && (rcnt_q == '0);
            rvalid_d = rd_en;
        end
        rptr_d = rd_en ? ptr_add(rptr_q, cnt_t'(1)) : rptr_q;
        // Commit and fetch deltas combine so a same-cycle read loses nothing.
        rcnt_d   = rcnt_q + commit_len - cnt_t'(rd_en);
        wcnt_d   = rcnt_d + flen_d;
        wfull_d  = (state_d == ST_IDLE) ? ((DEPTH_C - wcnt_d) < HEAD1_C)
                                        : (wcnt_d == DEPTH_C);
        wafull_d = (wcnt_d >= AFULL_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rptr_q   <= '0;
            cptr_q   <= '0;
            wptr_q   <= '0;
            flen_q   <= '0;
            rcnt_q   <= '0;
            wcnt_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            werr_q   <= 1'b0;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rptr_q   <= rptr_d;
            cptr_q   <= cptr_d;
            wptr_q   <= wptr_d;
            flen_q   <= flen_d;
            rcnt_q   <= rcnt_d;
            wcnt_q   <= wcnt_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            werr_q   <= werr_d;
            rerr_q   <= rerr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // The write strobe is combinational from w_ctrl, so it is masked during reset.
    assign w_ram_en   = wr_en & rst_n;
    assign w_ram_addr = rst_n ? wr_addr : '0;
    assign r_ram_en   = rd_en;
    assign r_ram_addr = rptr_q;
    assign w_full     = wfull_q;
    assign w_afull    = wafull_q;
    assign w_error    = werr_q;
    assign w_counter  = wcnt_q;
    assign r_valid    = rvalid_q;
    assign r_error    = rerr_q;
    assign r_counter  = rcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_syn_fifo_controller.sv
// ============================================================================
// Module   : tb_stream_syn_fifo_controller
// Brief    : Randomized bench for two controller configurations against a
//            frame-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_syn_fifo_controller;

    localparam int AW  = 6;
    localparam int D   = 44;
    localparam int AFT = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    w_ctrl = 3'd0;
    logic [AW-1:0] w_head_idx = '0;
    logic          r_en = 1'b0;

    logic          w_full_a [2];
    logic          w_afull_a [2];
    logic          w_error_a [2];
    logic          r_valid_a [2];
    logic          r_error_a [2];
    logic          w_ram_en_a [2];
    logic          r_ram_en_a [2];
    logic [AW:0]   w_counter_a [2];
    logic [AW:0]   r_counter_a [2];
    logic [AW-1:0] w_ram_addr_a [2];
    logic [AW-1:0] r_ram_addr_a [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_syn_fifo_controller #(
        .FWFTEN(1), .ADDRWIDTH(AW), .FIFODEPTH(D), .HEADSIZE(2), .AFULLTH(AFT), .DROPEN(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .w_ctrl(w_ctrl), .w_head_idx(w_head_idx),
        .w_full(w_full_a[0]), .w_afull(w_afull_a[0]), .w_error(w_error_a[0]),
        .w_counter(w_counter_a[0]), .r_en(r_en), .r_valid(r_valid_a[0]),
        .r_error(r_error_a[0]), .r_counter(r_counter_a[0]),
        .w_ram_addr(w_ram_addr_a[0]), .w_ram_en(w_ram_en_a[0]),
        .r_ram_addr(r_ram_addr_a[0]), .r_ram_en(r_ram_en_a[0])
    );

    stream_syn_fifo_controller #(
        .FWFTEN(0), .ADDRWIDTH(AW), .FIFODEPTH(D), .HEADSIZE(0), .AFULLTH(AFT), .DROPEN(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .w_ctrl(w_ctrl), .w_head_idx(w_head_idx),
        .w_full(w_full_a[1]), .w_afull(w_afull_a[1]), .w_error(w_error_a[1]),
        .w_counter(w_counter_a[1]), .r_en(r_en), .r_valid(r_valid_a[1]),
        .r_error(r_error_a[1]), .r_counter(r_counter_a[1]),
        .w_ram_addr(w_ram_addr_a[1]), .w_ram_en(w_ram_en_a[1]),
        .r_ram_addr(r_ram_addr_a[1]), .r_ram_en(r_ram_en_a[1])
    );

    function automatic int hs(input int k);
        return (k == 0) ? 2 : 0;
    endfunction
    function automatic bit fwft(input int k);
        return (k == 0);
    endfunction
    function automatic bit dropen(input int k);
        return (k == 1);
    endfunction

    // Frame-level model: frame start address, open frame length, committed
    // unread count and next read address.
    int m_state [2];
    int m_cstart [2];
    int m_flen [2];
    int m_rcnt [2];
    int m_raddr [2];
    int m_wcnt [2];
    bit m_valid [2];
    bit m_werr [2];
    bit m_rerr [2];
    bit m_wfull [2];
    bit m_wafull [2];

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[u%0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_state[k] = 0; m_cstart[k] = 0; m_flen[k] = 0; m_rcnt[k] = 0;
        m_raddr[k] = 0; m_wcnt[k] = 0; m_valid[k] = 0; m_werr[k] = 0;
        m_rerr[k] = 0; m_wfull[k] = 0; m_wafull[k] = 0;
    endtask

    task automatic step(input int k);
        int h, c, idx, we, wa, werr, add, ren, nst, nflen, ncs;
        chk("w_counter", k, int'(w_counter_a[k]), m_wcnt[k]);
        chk("r_counter", k, int'(r_counter_a[k]), m_rcnt[k]);
        chk("w_full", k, int'(w_full_a[k]), int'(m_wfull[k]));
        chk("w_afull", k, int'(w_afull_a[k]), int'(m_wafull[k]));
        chk("w_error", k, int'(w_error_a[k]), int'(m_werr[k]));
        chk("r_error", k, int'(r_error_a[k]), int'(m_rerr[k]));
        chk("r_valid", k, int'(r_valid_a[k]), int'(m_valid[k]));

        h = hs(k); c = int'(w_ctrl); idx = int'(w_head_idx);
        we = 0; wa = 0; werr = 0; add = 0;
        nst = m_state[k]; nflen = m_flen[k]; ncs = m_cstart[k];
        if (c > 4) begin
            werr = 1;
        end else if (m_state[k] == 0) begin
            if (c == 1) begin
                if (D - m_wcnt[k] >= h + 1) begin
                    we = 1; wa = (m_cstart[k] + h) % D; nflen = h + 1; nst = 1;
                end else begin
                    werr = 1;
                end
            end else if (c == 4) begin
                werr = 1;
            end
        end else if (m_state[k] == 1) begin
            if (c == 1) begin
                if (m_wcnt[k] < D) begin
                    we = 1; wa = (m_cstart[k] + m_flen[k]) % D; nflen = m_flen[k] + 1;
                end else begin
                    werr = 1;
                    if (dropen(k)) nst = 2;
                end
            end else if (c == 4) begin
                if (idx < h) begin
                    we = 1; wa = (m_cstart[k] + idx) % D;
                end else begin
                    werr = 1;
                end
            end else if (c == 2) begin
                add = m_flen[k]; ncs = (m_cstart[k] + m_flen[k]) % D; nflen = 0; nst = 0;
            end else if (c == 3) begin
                nflen = 0; nst = 0;
            end
        end else begin
            if (c == 2 || c == 3) begin
                nflen = 0; nst = 0;
            end
        end

        if (fwft(k)) ren = (m_rcnt[k] != 0 && (!m_valid[k] || r_en)) ? 1 : 0;
        else         ren = (r_en && m_rcnt[k] != 0) ? 1 : 0;

        chk("w_ram_en", k, int'(w_ram_en_a[k]), we);
        if (we != 0) chk("w_ram_addr", k, int'(w_ram_addr_a[k]), wa);
        chk("r_ram_en", k, int'(r_ram_en_a[k]), ren);
        if (ren != 0) chk("r_ram_addr", k, int'(r_ram_addr_a[k]), m_raddr[k]);

        if (fwft(k)) begin
            m_rerr[k]  = r_en && !m_valid[k];
            m_valid[k] = (ren != 0) ? 1'b1 : (r_en ? 1'b0 : m_valid[k]);
        end else begin
            m_rerr[k]  = r_en && (m_rcnt[k] == 0);
            m_valid[k] = (ren != 0);
        end
        m_werr[k]   = (werr != 0);
        m_rcnt[k]   = m_rcnt[k] + add - ren;
        m_raddr[k]  = (m_raddr[k] + ren) % D;
        m_state[k]  = nst;
        m_flen[k]   = nflen;
        m_cstart[k] = ncs;
        m_wcnt[k]   = m_rcnt[k] + m_flen[k];
        m_wfull[k]  = (nst == 0) ? (D - m_wcnt[k] < h + 1) : (m_wcnt[k] == D);
        m_wafull[k] = (m_wcnt[k] >= AFT);
    endtask

    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk("rst_w_counter", k, int'(w_counter_a[k]), 0);
                chk("rst_r_counter", k, int'(r_counter_a[k]), 0);
                chk("rst_flags", k, int'({w_full_a[k], w_afull_a[k], w_error_a[k], r_error_a[k], r_valid_a[k]}), 0);
                chk("rst_ram_en", k, int'({w_ram_en_a[k], r_ram_en_a[k]}), 0);
                model_reset(k);
            end else begin
                step(k);
            end
        end
    end

    task automatic cyc(input logic [2:0] c, input int idx, input logic re);
        @(negedge clk);
        w_ctrl = c;
        w_head_idx = AW'(idx);
        r_en = re;
    endtask

    initial begin
        int r;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("lit_reset_wcnt", 0, int'(w_counter_a[0]), 0);
        chk("lit_reset_full", 0, int'(w_full_a[0]), 0);

        repeat (3) cyc(3'd1, 0, 1'b0);
        cyc(3'd4, 0, 1'b0);
        cyc(3'd4, 1, 1'b0);
        cyc(3'd4, 2, 1'b0);
        cyc(3'd2, 0, 1'b0);
        cyc(3'd0, 0, 1'b0);
        #3;
        chk("lit_head_rcnt", 0, int'(r_counter_a[0]), 5);
        chk("lit_head_wcnt", 0, int'(w_counter_a[0]), 5);
        chk("lit_nohead_rcnt", 1, int'(r_counter_a[1]), 3);
        repeat (8) cyc(3'd0, 0, 1'b1);
        #3;
        chk("lit_drained", 0, int'(r_counter_a[0]), 0);
        chk("lit_drained", 1, int'(r_counter_a[1]), 0);

        repeat (10) cyc(3'd1, 0, 1'b0);
        cyc(3'd3, 0, 1'b0);
        repeat (3) cyc(3'd1, 0, 1'b0);
        cyc(3'd2, 0, 1'b0);
        cyc(3'd0, 0, 1'b0);
        #3;
        chk("lit_abort_rcnt", 0, int'(r_counter_a[0]), 5);
        chk("lit_abort_rcnt", 1, int'(r_counter_a[1]), 3);
        chk("lit_abort_wcnt", 1, int'(w_counter_a[1]), 3);
        repeat (8) cyc(3'd0, 0, 1'b1);

        repeat (44) cyc(3'd1, 0, 1'b0);
        cyc(3'd1, 0, 1'b0);
        #3;
        chk("lit_full_44", 1, int'(w_full_a[1]), 1);
        chk("lit_full_h2", 0, int'(w_full_a[0]), 1);
        cyc(3'd2, 0, 1'b0);
        #3;
        chk("lit_overflow_err", 1, int'(w_error_a[1]), 1);
        cyc(3'd0, 0, 1'b0);
        #3;
        chk("lit_drop_wcnt", 1, int'(w_counter_a[1]), 0);
        chk("lit_drop_rcnt", 1, int'(r_counter_a[1]), 0);
        chk("lit_commit44_rcnt", 0, int'(r_counter_a[0]), 44);
        repeat (50) cyc(3'd0, 0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] c;
            r = int'($urandom_range(0, 99));
            if (r < 50)      c = 3'd1;
            else if (r < 58) c = 3'd2;
            else if (r < 62) c = 3'd3;
            else if (r < 72) c = 3'd4;
            else if (r < 74) c = 3'(5 + $urandom_range(0, 2));
            else             c = 3'd0;
            cyc(c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (4) cyc(3'd1, 0, 1'b0);
        @(negedge clk);
        w_ctrl = 3'd1;
        rst_n = 1'b0;
        #3;
        chk("lit_midreset_wen", 0, int'(w_ram_en_a[0]), 0);
        chk("lit_midreset_wcnt", 1, int'(w_counter_a[1]), 0);
        repeat (2) cyc(3'd1, 0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        w_ctrl = 3'd0;
        r_en = 1'b1;
        #3;
        chk("lit_empty_rerr_pre", 1, int'(r_error_a[1]), 0);
        cyc(3'd0, 0, 1'b0);
        #3;
        chk("lit_empty_rerr", 1, int'(r_error_a[1]), 1);
        for (int i = 0; i < 300; i++) begin
            cyc(3'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        cyc(3'd0, 0, 1'b0);
        @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
